// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the iterative binary<->BCD converter.
//   state_t          : converter FSM states
//   MODE_B2D/D2B     : operation select values for the mode input
//   nib_add3/sub3    : per-nibble adjust used by double-dabble and its reverse
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_B2D = 1'b0;
  localparam logic MODE_D2B = 1'b1;

  // Forward adjust: a digit >= 5 would become >= 10 after the left shift.
  function automatic logic [3:0] nib_add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Reverse adjust: after a right shift a nibble >= 8 means the bit that
  // crossed in from the digit above weighed 5, not 8.
  function automatic logic [3:0] nib_sub3(input logic [3:0] n);
    return (n >= 4'd8) ? n - 4'd3 : n;
  endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One combinational double-dabble step on the working register
// W = {bcd[DIGITS*4], bin[WIDTH]}.
//   w_in      : working register before the step
//   mode      : 0 = bin->BCD (adjust then shift left), 1 = BCD->bin (shift right then adjust)
//   w_out     : working register after the step
//   carry_out : bit pushed out of the BCD MSB (bin->BCD only, else 0)
module bcd_dd_step
  import bcd_conv_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic [DIGITS*4+WIDTH-1:0] w_in,
  input  logic                      mode,
  output logic [DIGITS*4+WIDTH-1:0] w_out,
  output logic                      carry_out
);

  localparam int TW = DIGITS*4 + WIDTH;

  logic [TW-1:0] adj;
  logic [TW-1:0] sh;

  always_comb begin
    adj       = w_in;
    sh        = '0;
    w_out     = w_in;
    carry_out = 1'b0;
    if (mode == MODE_B2D) begin
      for (int i = 0; i < DIGITS; i++) begin
        adj[WIDTH+4*i +: 4] = nib_add3(w_in[WIDTH+4*i +: 4]);
      end
      carry_out = adj[TW-1];
      w_out     = {adj[TW-2:0], 1'b0};
    end else begin
      sh    = {1'b0, w_in[TW-1:1]};
      w_out = sh;
      for (int i = 0; i < DIGITS; i++) begin
        w_out[WIDTH+4*i +: 4] = nib_sub3(sh[WIDTH+4*i +: 4]);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_dd.sv
// Iterative bidirectional binary<->BCD converter with valid/ready handshakes.
// STEPS double-dabble steps are chained per clock; WIDTH/STEPS clocks per result.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (in_ready only while idle)
//   mode                : 0 = bin->BCD, 1 = BCD->bin, captured at accept
//   bin_in / bcd_in     : operands (bcd digit 0 in the LS nibble)
//   out_valid/out_ready : result handshake, result held until taken
//   bin_out / bcd_out   : results (the unused one reads as zero)
//   mode_out            : mode of the presented result
//   ovf                 : result truncated (did not fit)
//   err_digit           : BCD operand contained a nibble above 9
module bcd_conv_dd
  import bcd_conv_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int STEPS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic [DIGITS*4-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      bin_out,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  mode_out,
  output logic                  ovf,
  output logic                  err_digit
);

  localparam int BW   = DIGITS*4;
  localparam int TW   = BW + WIDTH;
  localparam int ITER = WIDTH / STEPS;
  localparam int CW   = $clog2(ITER + 1);

  if (STEPS < 1 || (WIDTH % STEPS) != 0) begin : g_bad_steps
    $error("bcd_conv_dd: STEPS must be >= 1 and divide WIDTH");
  end

  state_t        state;
  logic [CW-1:0] count;
  logic          mode_r;
  logic          ovf_acc;
  logic [TW-1:0] w;
  logic [TW-1:0] chain [STEPS+1];
  logic [STEPS-1:0] carry;
  logic          accept;
  logic          bad_digit;
  logic          run_last;
  logic [TW-1:0] w_next;
  logic          ovf_next;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign run_last = (count == CW'(1));
  assign w_next   = chain[STEPS];
  assign ovf_next = ovf_acc | (|carry);

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Combinational step chain: STEPS steps per clock
  assign chain[0] = w;
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    bcd_dd_step #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
    ) u_step (
      .w_in      (chain[g]),
      .mode      (mode_r),
      .w_out     (chain[g+1]),
      .carry_out (carry[g])
    );
  end

  // Working register: loaded at accept, advanced every RUN clock
  always_ff @(posedge clk) begin
    if (accept) begin
      mode_r  <= mode;
      ovf_acc <= 1'b0;
      w       <= (mode == MODE_D2B) ? {bcd_in, {WIDTH{1'b0}}} : {{BW{1'b0}}, bin_in};
    end else if (state == S_RUN) begin
      w       <= w_next;
      ovf_acc <= ovf_next;
    end
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
      bcd_out   <= '0;
      mode_out  <= 1'b0;
      ovf       <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            count <= CW'(ITER);
            if (mode == MODE_D2B && bad_digit) begin
              // Malformed BCD: report immediately with zeroed results.
              state     <= S_DONE;
              out_valid <= 1'b1;
              bin_out   <= '0;
              bcd_out   <= '0;
              mode_out  <= MODE_D2B;
              ovf       <= 1'b0;
              err_digit <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          count <= count - CW'(1);
          if (run_last) begin
            // Results are taken straight from the last step of the chain.
            state     <= S_DONE;
            out_valid <= 1'b1;
            mode_out  <= mode_r;
            err_digit <= 1'b0;
            if (mode_r == MODE_B2D) begin
              bcd_out <= w_next[TW-1:WIDTH];
              bin_out <= '0;
              ovf     <= ovf_next;
            end else begin
              bin_out <= w_next[WIDTH-1:0];
              bcd_out <= '0;
              ovf     <= |w_next[TW-1:WIDTH];
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_dd.sv
// Self-checking bench for bcd_conv_dd: several parameterisations side by side,
// directed cases plus a randomized sweep against a decimal-arithmetic model.
module tb_bcd_conv_dd;

  localparam int NK = 6;
  // instance:                   0   1   2   3   4   5
  localparam int WS [NK] = '{ 8, 16,  8, 16, 16, 16};
  localparam int DS [NK] = '{ 3,  5,  2,  5,  5,  5};
  localparam int SS [NK] = '{ 1,  4,  1,  1,  2,  8};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NK-1:0]       in_valid  = '0;
  logic [NK-1:0]       in_ready;
  logic [NK-1:0]       mode      = '0;
  logic [NK-1:0][15:0] bin_in    = '0;
  logic [NK-1:0][19:0] bcd_in    = '0;
  logic [NK-1:0]       out_valid;
  logic [NK-1:0]       out_ready = '0;
  logic [NK-1:0][15:0] bin_out;
  logic [NK-1:0][19:0] bcd_out;
  logic [NK-1:0]       mode_out;
  logic [NK-1:0]       ovf;
  logic [NK-1:0]       err_digit;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NK; k++) begin : g_dut
    localparam int W = WS[k];
    localparam int D = DS[k];
    localparam int S = SS[k];
    logic [W-1:0]   bo;
    logic [4*D-1:0] co;
    bcd_conv_dd #(.WIDTH(W), .DIGITS(D), .STEPS(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .mode      (mode[k]),
      .bin_in    (bin_in[k][W-1:0]),
      .bcd_in    (bcd_in[k][4*D-1:0]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .bin_out   (bo),
      .bcd_out   (co),
      .mode_out  (mode_out[k]),
      .ovf       (ovf[k]),
      .err_digit (err_digit[k])
    );
    assign bin_out[k] = 16'(bo);
    assign bcd_out[k] = 20'(co);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed result vector {mode_out, ovf, err_digit, bin_out, bcd_out}
  function automatic logic [38:0] obs(input int k);
    return {mode_out[k], ovf[k], err_digit[k], bin_out[k], bcd_out[k]};
  endfunction

  // Reference: plain decimal arithmetic on the operand values.
  function automatic logic [38:0] ref_model(input int k, input logic m,
                                            input logic [15:0] b, input logic [19:0] d);
    longint v;
    longint pw;
    logic [15:0] eb;
    logic [19:0] ed;
    logic eo, ee;
    eb = '0; ed = '0; eo = 1'b0; ee = 1'b0;
    if (!m) begin
      v = longint'(b) & ((longint'(1) << WS[k]) - 1);
      for (int i = 0; i < DS[k]; i++) begin
        ed[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
      eo = (v != 0);
    end else begin
      v = 0; pw = 1;
      for (int i = 0; i < DS[k]; i++) begin
        if (d[4*i +: 4] > 4'd9) ee = 1'b1;
        v  = v + longint'(d[4*i +: 4]) * pw;
        pw = pw * 10;
      end
      if (!ee) begin
        eb = 16'(v % (longint'(1) << WS[k]));
        eo = (v >= (longint'(1) << WS[k]));
      end
    end
    return {m, eo, ee, eb, ed};
  endfunction

  // Present one request, then wait (bounded) for out_valid; lat counts
  // rising edges after the accept edge. Operands are scrambled after accept.
  task automatic do_txn(input int k, input logic m, input logic [15:0] b,
                        input logic [19:0] d, output int lat, output bit to);
    @(negedge clk);
    mode[k] = m; bin_in[k] = b; bcd_in[k] = d;
    in_valid[k] = 1'b1; out_ready[k] = 1'b0;
    @(negedge clk);
    in_valid[k] = 1'b0; bin_in[k] = ~b; bcd_in[k] = ~d; mode[k] = ~m;
    lat = 0;
    while (!out_valid[k] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    to = !out_valid[k];
  endtask

  task automatic drain(input int k);
    @(negedge clk) out_ready[k] = 1'b1;
    @(negedge clk) out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      vec_cnt++;
      if ({out_valid[k], in_ready[k], obs(k)} !== {1'b0, 1'b1, 39'h0}) begin
        miss_cnt++;
        $display("FAIL reset[%0d]: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=0",
                 k, out_valid[k], in_ready[k], obs(k));
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Directed conversion with literal expected result and latency
  task automatic test_directed(input string name, input int k, input logic m,
                               input logic [15:0] b, input logic [19:0] d,
                               input logic [38:0] exp, input int exp_lat);
    int lat; bit to;
    do_txn(k, m, b, d, lat, to);
    vec_cnt++;
    if (to || lat != exp_lat) begin
      miss_cnt++;
      $display("FAIL %s latency: got %0d (timeout=%0b), want %0d", name, lat, to, exp_lat);
    end
    vec_cnt++;
    if (obs(k) !== exp) begin
      miss_cnt++;
      $display("FAIL %s result: got %h, want %h", name, obs(k), exp);
    end
    drain(k);
  endtask

  task automatic test_hold();
    int lat; bit to;
    logic [38:0] snap;
    do_txn(0, 1'b0, 16'd137, 20'h0, lat, to);
    snap = {1'b0, 1'b0, 1'b0, 16'h0, 20'h00137};
    for (int i = 0; i < 10; i++) begin
      vec_cnt++;
      if ({out_valid[0], in_ready[0], obs(0)} !== {1'b1, 1'b0, snap}) begin
        miss_cnt++;
        $display("FAIL hold cycle %0d: got vld=%b rdy=%b res=%h, want vld=1 rdy=0 res=%h",
                 i, out_valid[0], in_ready[0], obs(0), snap);
      end
      in_valid[0] = (i % 2 == 0);
      bin_in[0]   = 16'($urandom);
      mode[0]     = 1'($urandom);
      @(negedge clk);
    end
    // Single out_ready cycle with a competing request: must not be accepted.
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    vec_cnt++;
    if ({out_valid[0], in_ready[0], obs(0)} !== {1'b0, 1'b1, snap}) begin
      miss_cnt++;
      $display("FAIL hold release: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=%h",
               out_valid[0], in_ready[0], obs(0), snap);
    end
    @(negedge clk);
    vec_cnt++;
    if ({out_valid[0], in_ready[0]} !== 2'b01) begin
      miss_cnt++;
      $display("FAIL hold no-accept-in-done: got vld=%b rdy=%b, want vld=0 rdy=1",
               out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_rst_mid_run();
    bit seen;
    @(negedge clk);
    mode[0] = 1'b0; bin_in[0] = 16'd99; in_valid[0] = 1'b1;
    @(negedge clk) in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({out_valid[0], in_ready[0], obs(0)} !== {1'b0, 1'b1, 39'h0}) begin
      miss_cnt++;
      $display("FAIL rst_mid: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=0",
               out_valid[0], in_ready[0], obs(0));
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    vec_cnt++;
    if (seen) begin
      miss_cnt++;
      $display("FAIL rst_mid emitted: got out_valid=1 after abort, want 0");
    end
    test_directed("rst_mid fresh", 0, 1'b0, 16'd99, 20'h0, {3'b000, 16'h0, 20'h00099}, 8);
  endtask

  task automatic test_back_to_back();
    int cyc, t1, t2;
    bit prev;
    @(negedge clk);
    mode[1] = 1'b0; bin_in[1] = 16'd1234; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    cyc = 0; t1 = -1; t2 = -1; prev = 1'b0;
    while (cyc < 40 && t2 < 0) begin
      @(negedge clk);
      cyc++;
      if (out_valid[1] && !prev) begin
        if (t1 < 0) begin
          t1 = cyc;
          vec_cnt++;
          if (obs(1) !== {3'b000, 16'h0, 20'h01234}) begin
            miss_cnt++;
            $display("FAIL b2b result: got %h, want %h", obs(1), {3'b000, 16'h0, 20'h01234});
          end
        end else begin
          t2 = cyc;
        end
      end
      prev = out_valid[1];
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    vec_cnt++;
    if (t1 < 0 || t2 < 0 || (t2 - t1) != 6) begin
      miss_cnt++;
      $display("FAIL b2b spacing: got t1=%0d t2=%0d, want spacing 6", t1, t2);
    end
    drain(1);
  endtask

  task automatic test_random(input int n);
    int lat; bit to;
    logic m;
    logic [15:0] b;
    logic [19:0] d;
    logic [38:0] exp;
    for (int k = 0; k < NK; k++) begin
      for (int t = 0; t < n; t++) begin
        m = 1'($urandom);
        b = 16'($urandom);
        if ($urandom_range(7, 0) == 0) b = 16'hFFFF;
        d = '0;
        for (int i = 0; i < DS[k]; i++) d[4*i +: 4] = 4'($urandom_range(9, 0));
        if ($urandom_range(7, 0) == 0)
          d[4*$urandom_range(DS[k]-1, 0) +: 4] = 4'($urandom_range(15, 10));
        exp = ref_model(k, m, b, d);
        do_txn(k, m, b, d, lat, to);
        vec_cnt++;
        if (to || lat != (exp[36] ? 0 : WS[k] / SS[k])) begin
          miss_cnt++;
          $display("FAIL rand[%0d] latency: got %0d (timeout=%0b), want %0d",
                   k, lat, to, exp[36] ? 0 : WS[k] / SS[k]);
        end
        vec_cnt++;
        if (obs(k) !== exp) begin
          miss_cnt++;
          $display("FAIL rand[%0d] m=%b b=%h d=%h: got %h, want %h", k, m, b, d, obs(k), exp);
        end
        drain(k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("b2d 255 W8",     0, 1'b0, 16'd255,   20'h0,     {3'b000, 16'h0,    20'h00255}, 8);
    test_directed("b2d 65535 S4",   1, 1'b0, 16'hFFFF,  20'h0,     {3'b000, 16'h0,    20'h65535}, 4);
    test_directed("d2b 65535 S4",   1, 1'b1, 16'h0,     20'h65535, {3'b100, 16'hFFFF, 20'h0},     4);
    test_directed("d2b ovf 256",    0, 1'b1, 16'h0,     20'h00256, {3'b110, 16'h0,    20'h0},     8);
    test_directed("b2d ovf 200 D2", 2, 1'b0, 16'd200,   20'h0,     {3'b010, 16'h0,    20'h00},    8);
    test_directed("d2b err 2A5",    0, 1'b1, 16'h0,     20'h002A5, {3'b101, 16'h0,    20'h0},     0);
    test_hold();
    test_rst_mid_run();
    test_back_to_back();
    test_random(25);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
